// File: rtl/alu_sched.sv
// alu_sched: round-robin sequencer in front of the shared ALU datapath.
// Two requesters issue operations. Exactly one operation is in flight at a time.
// Ops 000..110 complete in a single EXEC cycle. Op 111 (mod) launches the
// multi-cycle mod unit with alu_start and waits for alu_done.
// Each result is returned on one tagged response channel.
//
// Optional feature: define ALU_SCHED_TIMEOUT_EN to add a WAIT_MOD watchdog.
// After MOD_TIMEOUT cycles without alu_done, the op is answered with
// rsp_err=1 and rsp_data=0.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op     requester N handshake and operands (ready is combinational)
//   rsp_valid/ready/id/data/err tagged response channel
//   alu_a/alu_b/alu_s           registered ALU operands and select
//   alu_start                   one-cycle mod launch pulse
//   alu_result, alu_done        ALU/mod result and mod completion flag
module alu_sched #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MOD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_s,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done
);

  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [2:0] {IDLE, EXEC, START, WAIT_MOD, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   sel_c;
  logic   accept_c;
  logic   is_mod_c;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MOD_TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  localparam int unsigned unused_mod_timeout = MOD_TIMEOUT;
`endif

  // Round-robin pick: a lone valid wins; on contention the one not served last.
  always_comb begin
    sel_c = 1'b0;
    if (req0_valid && req1_valid) sel_c = ~last_grant;
    else if (req1_valid)          sel_c = 1'b1;
  end

  // Grant only while idle and out of reset, so ready reads 0 during reset.
  assign req0_ready = (state == IDLE) && reset && req0_valid && !sel_c;
  assign req1_ready = (state == IDLE) && reset && req1_valid &&  sel_c;
  assign accept_c   = req0_ready || req1_ready;
  assign is_mod_c   = (sel_c ? req1_op : req0_op) == OP_MOD;

  // Sequencer state, operand latches and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= 3'b000;
      alu_start  <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      alu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            alu_a      <= sel_c ? req1_a  : req0_a;
            alu_b      <= sel_c ? req1_b  : req0_b;
            alu_s      <= sel_c ? req1_op : req0_op;
            rsp_id     <= sel_c;
            last_grant <= sel_c;
            alu_start  <= is_mod_c;
            state      <= is_mod_c ? START : EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        START: begin
`ifdef ALU_SCHED_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= WAIT_MOD;
        end
        WAIT_MOD: begin
          // Completion takes priority over a coincident timeout.
          if (alu_done) begin
            rsp_data  <= alu_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (wd_cnt == CNT_W'(MOD_TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a behavioural ALU/mod model.
// The ALU model implements: 000 add, 001 sub, 010 and, 111 mod (mod_res), others or.
module tb_alu_sched;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MOD_TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_s;
  logic             alu_start, alu_done;
  logic [WIDTH-1:0] mod_res;

  int n_cmp = 0;
  int n_err = 0;

  alu_sched #(.WIDTH(WIDTH), .MOD_TIMEOUT(MOD_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: result muxed by select, mod result supplied by the bench.
  always_comb begin
    case (alu_s)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b111:  alu_result = mod_res;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle transaction with both requesters held valid.
  task automatic txn(input int exp_id, input logic [31:0] exp_data);
    check("rr_grant_ready", 32'(req0_ready | req1_ready), 32'd1);
    check("rr_grant_id", 32'(req1_ready), 32'(exp_id));
    cyc();
    #1;
    check("rr_exec_no_ready", 32'(req0_ready | req1_ready), 32'd0);
    check("rr_exec_no_rsp", 32'(rsp_valid), 32'd0);
    cyc();
    check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rr_rsp_id", 32'(rsp_id), 32'(exp_id));
    check("rr_rsp_data", rsp_data, exp_data);
    #1;
    check("rr_resp_no_ready", 32'(req0_ready | req1_ready), 32'd0);
    cyc();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    int early;
    reset = 1'b0; rsp_ready = 1'b1; alu_done = 1'b0; mod_res = '0;
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd5; req0_op = 3'b000;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 3'b000;
    cyc(); cyc();

    // Reset state.
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_s", 32'(alu_s), 32'd0);
    check("rst_alu_start", 32'(alu_start), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Single request 7+5 from req0.
    reset = 1'b1;
    #1;
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    cyc();
    req0_valid = 1'b0;
    check("t1_alu_a", alu_a, 32'd7);
    check("t1_alu_b", alu_b, 32'd5);
    check("t1_alu_s", 32'(alu_s), 32'd0);
    check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
    cyc();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_id", 32'(rsp_id), 32'd0);
    check("t1_rsp_data", rsp_data, 32'd12);
    check("t1_rsp_err", 32'(rsp_err), 32'd0);
    cyc();
    check("t1_rsp_drop", 32'(rsp_valid), 32'd0);

    // Round robin from reset: req0 10-3=7, req1 6&3=2.
    reset = 1'b0; cyc(); reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd6;  req1_b = 32'd3; req1_op = 3'b010;
    #1;
    for (int k = 0; k < 4; k++) txn(k % 2, (k % 2 == 1) ? 32'd2 : 32'd7);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();

    // Stray done in IDLE, then req1 mod 100 % 7 with done 10 cycles after start.
    alu_done = 1'b1; cyc(); alu_done = 1'b0;
    check("stray_done_ignored", 32'(rsp_valid), 32'd0);
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd7; req1_op = 3'b111;
    #1;
    check("mod_ready1", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    check("mod_start", 32'(alu_start), 32'd1);
    check("mod_alu_s", 32'(alu_s), 32'd7);
    check("mod_alu_a", alu_a, 32'd100);
    cnt = 0; early = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (alu_start) cnt++;
      if (rsp_valid) early++;
    end
    check("mod_start_single", 32'(cnt), 32'd0);
    check("mod_no_early_rsp", 32'(early), 32'd0);
    alu_done = 1'b1; mod_res = 32'd2; rsp_ready = 1'b0;
    cyc();
    alu_done = 1'b0;
    check("mod_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mod_rsp_data", rsp_data, 32'd2);
    check("mod_rsp_id", 32'(rsp_id), 32'd1);
    check("mod_rsp_err", 32'(rsp_err), 32'd0);

    // Backpressure: response held 5 cycles, no accept meanwhile.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    mod_res = 32'd99;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_data, 32'd2);
      check("bp_no_ready", 32'(req0_ready), 32'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_no_ready_hs", 32'(req0_ready), 32'd0);
    cyc();
    #1;
    check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
    check("bp_ready_after", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    check("bp_accept_a", alu_a, 32'd1);
    cyc();
    check("bp_rsp_data", rsp_data, 32'd3);
    check("bp_rsp_id", 32'(rsp_id), 32'd0);
    cyc();

    // Mod that never completes.
    mod_res = 32'hdead_beef;
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 3'b111;
    #1;
    check("to_ready0", 32'(req0_ready), 32'd1);
    cyc();
    req0_valid = 1'b0;
    cyc();
`ifdef ALU_SCHED_TIMEOUT_EN
    cnt = 0;
    while (!rsp_valid && cnt < 30) begin
      cyc();
      cnt++;
    end
    check("to_cycles", 32'(cnt), 32'd8);
    check("to_rsp_err", 32'(rsp_err), 32'd1);
    check("to_rsp_data", rsp_data, 32'd0);
    check("to_rsp_id", 32'(rsp_id), 32'd0);
    cyc();
`else
    early = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (rsp_valid) early++;
    end
    check("to_no_rsp", 32'(early), 32'd0);
`endif

    // Reset during WAIT_MOD.
    reset = 1'b0; cyc(); reset = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd50; req1_b = 32'd6; req1_op = 3'b111;
    #1;
    check("rw_ready1", 32'(req1_ready), 32'd1);
    cyc();
    req1_valid = 1'b0;
    cyc(); cyc();
    check("rw_alu_a_pre", alu_a, 32'd50);
    reset = 1'b0;
    req0_valid = 1'b1;
    cyc();
    check("rw_alu_a", alu_a, 32'd0);
    check("rw_alu_b", alu_b, 32'd0);
    check("rw_alu_s", 32'(alu_s), 32'd0);
    check("rw_alu_start", 32'(alu_start), 32'd0);
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_rsp_id", 32'(rsp_id), 32'd0);
    check("rw_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    reset = 1'b1;
    alu_done = 1'b1; mod_res = 32'd5;
    cyc();
    alu_done = 1'b0;
    cyc(); cyc();
    check("rw_late_done_ignored", 32'(rsp_valid), 32'd0);
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b000;
    req1_valid = 1'b1;
    #1;
    check("rw_first_ready0", 32'(req0_ready), 32'd1);
    check("rw_first_ready1", 32'(req1_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Sequencer and two-port arbiter in front of the shared ALU datapath (single-cycle 32-bit ops on S=000..110, multi-cycle mod on S=111). Accepts operation requests from two requesters, grants them round-robin, drives the ALU operand/select inputs, launches and tracks the mod unit until its done flag, and returns each result on one tagged response channel. Exactly one operation is in flight at a time.

## Interface
- WIDTH, 32, operand/result width
- MOD_TIMEOUT, 64, maximum WAIT_MOD cycles before abort (used only with watchdog compiled in)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has an operation
- req0_ready / req1_ready  out  1  requester N accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_op / req1_op  in  3  ALU select, 111 = mod
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_data  out  WIDTH  result
- rsp_err  out  1  mod aborted by watchdog
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_s  out  3  ALU select
- alu_start  out  1  one-cycle mod launch pulse
- alu_result  in  WIDTH  ALU/mod result (muxed by S)
- alu_done  in  1  mod complete

## Operation
- States: IDLE, EXEC, START, WAIT_MOD, RESP.
- IDLE: grant chosen among valid requesters; granted reqN_ready=1 combinationally, the other 0; a and b plus op and id latched on valid&ready.
- Arbitration: one valid → it wins; both valid → the one not served last; last_grant resets to 1, so req0 wins first contest.
- op≠111: IDLE→EXEC→RESP; alu_result captured at end of EXEC.
- op=111: IDLE→START (alu_start=1)→WAIT_MOD; on alu_done=1 capture alu_result→RESP.
- RESP: rsp_valid=1, rsp_id/data/err stable until rsp_ready=1, then →IDLE; no request accepted in that cycle.
- alu_a/alu_b/alu_s registered; stable from EXEC/START until next accept; change only on accept.
- alu_done outside WAIT_MOD ignored.
- Reset: state IDLE, all outputs 0 (ready, rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_s, alu_start), last_grant=1, watchdog count 0. Reset mid-operation abandons the op, no response issued.

## Timing
- Accept at edge N (valid&ready sampled).
- Single-cycle op: EXEC during N+1, rsp_valid high from N+2 (latency 2).
- Mod: alu_start high exactly during N+1; WAIT_MOD from N+2; alu_done first seen high at edge M → rsp_valid high from M+1.
- rsp_valid&rsp_ready at edge R → IDLE at R+1; next accept earliest edge R+1; back-to-back single-cycle throughput 1 op / 3 cycles with rsp_ready held 1.
- Requester changes or drops valid while not granted: no effect, no latching.

## Configuration
- ALU_SCHED_TIMEOUT_EN defined: counter runs in WAIT_MOD; after MOD_TIMEOUT cycles without alu_done → RESP with rsp_err=1, rsp_data=0. alu_done and timeout on same cycle: done wins, rsp_err=0.
- Undefined: no counter; WAIT_MOD waits indefinitely; rsp_err tied 0; MOD_TIMEOUT unused.

## Test plan
- req0 A=7,B=5,op=000 alone, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=ALU result for 7,5 op 000, rsp_err=0.
- Both valid from reset, held, rsp_ready=1 → grants in order 0,1,0,1; rsp_id sequence matches; never two accepts without intervening response.
- req1 mod A=100,B=7; model asserts alu_done 10 cycles after alu_start with result 2 → alu_start single pulse, rsp_data=2, rsp_id=1, rsp_valid cycle after done.
- rsp_ready held 0 for 5 cycles in RESP → rsp_valid/data stable, both reqN_ready=0; accept only cycle after rsp_ready=1.
- With ALU_SCHED_TIMEOUT_EN, MOD_TIMEOUT=8, alu_done never → rsp_err=1, rsp_data=0 after 8 WAIT_MOD cycles; without macro → no response after 100 cycles.
- reset=0 asserted during WAIT_MOD → next edge all outputs 0, IDLE; later alu_done ignored; req0 accepted first afterwards.
